// File: rtl/inv_toggle_ctrl_if.sv
// Control, status and stimulus bundle for inv_toggle_ctrl.
//
// Signals:
//   start, abort, num_toggles   run control from the requester.
//   busy, done, pass            run status back to the requester.
//   toggle_cnt, err_cnt         run counters.
//   dut_a                       drive to the inverter input.
//   dut_y                       inverter output, synchronous to the controller clock.
//
// Modports:
//   slave  - the controller (inv_toggle_ctrl).
//   master - the environment: requester plus the inverter under test.
interface inv_toggle_ctrl_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_toggles;
    logic             dut_a;
    logic             dut_y;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] toggle_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             pass;

    modport master (
        output start, abort, num_toggles, dut_y,
        input  dut_a, busy, done, toggle_cnt, err_cnt, pass
    );

    modport slave (
        input  start, abort, num_toggles, dut_y,
        output dut_a, busy, done, toggle_cnt, err_cnt, pass
    );
endinterface

// File: rtl/inv_toggle_ctrl.sv
// Stimulus sequencer and self-checker for one inverter stage.
//
// After start is accepted (cycle 0) dut_a starts at 0 and inverts every HALF_PERIOD cycles,
// num_toggles times. SETTLE cycles after each toggle dut_y is sampled and compared with
// ~dut_a; mismatches bump a saturating error counter. A one-cycle done pulse ends the run and
// pass records whether no check failed. abort ends a run early without done.
//
// Ports:
//   clk     rising-edge clock.
//   rst_n   asynchronous active-low reset.
//   bus     inv_toggle_ctrl_if.slave: start/abort/num_toggles in, dut_a out, dut_y in,
//           busy/done/toggle_cnt/err_cnt/pass out.
//
// Parameters:
//   HALF_PERIOD  cycles between toggles, 2..255.
//   SETTLE       cycles from a toggle to its check, 1 <= SETTLE < HALF_PERIOD.
//   CNT_W        width of num_toggles and both counters; must match the interface.
//
// Build option:
//   INV_TOGGLE_CTRL_PRECHECK_EN - adds one static check (expect dut_y=1 with dut_a=0) at
//   cycle SETTLE, before the first toggle. The toggle schedule is unaffected.
module inv_toggle_ctrl #(
    parameter int unsigned HALF_PERIOD = 10,
    parameter int unsigned SETTLE      = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    inv_toggle_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StSettle,
        StCheck,
        StDone
    } state_e;

    // First wait spans a full half period; later waits start after SETTLE cycles of
    // settle/check have already elapsed since the previous toggle.
    localparam logic [7:0] HalfLd   = 8'(HALF_PERIOD);
    localparam logic [7:0] ReloadLd = 8'(HALF_PERIOD - SETTLE);
    localparam logic [7:0] SettleLd = 8'(SETTLE - 1);
`ifdef INV_TOGGLE_CTRL_PRECHECK_EN
    // Timer value during cycle SETTLE-1 of the first wait, so the result shows at cycle SETTLE.
    localparam logic [7:0] PreAt    = 8'(HALF_PERIOD - SETTLE + 1);
`endif

    state_e           state_q;
    logic [7:0]       timer_q;
    logic [CNT_W-1:0] n_q;
    logic [CNT_W-1:0] toggle_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic             dut_a_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    logic             y_bad;
    logic [CNT_W-1:0] err_inc;

    // A healthy inverter output is the complement of its input.
    assign y_bad   = (bus.dut_y == dut_a_q);
    assign err_inc = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            n_q          <= '0;
            toggle_cnt_q <= '0;
            err_cnt_q    <= '0;
            dut_a_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.abort) begin
                // In IDLE abort only blocks start acceptance.
                if (state_q != StIdle) begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    dut_a_q <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bus.start) begin
                            toggle_cnt_q <= '0;
                            err_cnt_q    <= '0;
                            pass_q       <= 1'b0;
                            busy_q       <= 1'b1;
                            if (bus.num_toggles != '0) begin
                                n_q     <= bus.num_toggles;
                                dut_a_q <= 1'b0;
                                timer_q <= HalfLd;
                                state_q <= StWait;
                            end else begin
                                // Empty run: straight to done, dut_a left alone.
                                state_q <= StDone;
                            end
                        end
                    end
                    StWait: begin
`ifdef INV_TOGGLE_CTRL_PRECHECK_EN
                        if (toggle_cnt_q == '0 && timer_q == PreAt && y_bad) begin
                            err_cnt_q <= err_inc;
                        end
`endif
                        if (timer_q == 8'd1) begin
                            dut_a_q      <= ~dut_a_q;
                            toggle_cnt_q <= toggle_cnt_q + 1'b1;
                            if (SETTLE == 1) begin
                                state_q <= StCheck;
                            end else begin
                                timer_q <= SettleLd;
                                state_q <= StSettle;
                            end
                        end else begin
                            timer_q <= timer_q - 8'd1;
                        end
                    end
                    StSettle: begin
                        if (timer_q == 8'd1) begin
                            state_q <= StCheck;
                        end else begin
                            timer_q <= timer_q - 8'd1;
                        end
                    end
                    StCheck: begin
                        if (y_bad) begin
                            err_cnt_q <= err_inc;
                        end
                        if (toggle_cnt_q == n_q) begin
                            state_q <= StDone;
                        end else begin
                            timer_q <= ReloadLd;
                            state_q <= StWait;
                        end
                    end
                    StDone: begin
                        // err_cnt_q already includes the final check's result here.
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        pass_q  <= (err_cnt_q == '0);
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.dut_a      = dut_a_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.toggle_cnt = toggle_cnt_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.pass       = pass_q;

endmodule
